// File: rtl/softmax_uart_pkg.sv
// Shared definitions for the softmax UART link: Q6.10 word format, frame length,
// FSM state encodings and the baud divider helper.
package softmax_uart_pkg;

    localparam int unsigned Q_W         = 16;
    localparam int unsigned Q_FRAC      = 10;
    localparam int unsigned FRAME_WORDS = 64;

    typedef logic [1:0] word_state_t;
    localparam word_state_t WS_IDLE    = 2'd0;
    localparam word_state_t WS_SEND_LO = 2'd1;
    localparam word_state_t WS_SEND_HI = 2'd2;

    typedef logic [1:0] byte_state_t;
    localparam byte_state_t BS_IDLE  = 2'd0;
    localparam byte_state_t BS_START = 2'd1;
    localparam byte_state_t BS_DATA  = 2'd2;
    localparam byte_state_t BS_STOP  = 2'd3;

    function automatic int unsigned bit_clks(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_softmax_tx_if.sv
// Valid/ready word handshake from the softmax core into the UART transmitter.
interface uart_softmax_tx_if;
    import softmax_uart_pkg::*;

    logic             in_valid_i;
    logic [Q_W-1:0]   in_data_i;
    logic             in_ready_o;

    modport master (output in_valid_i, output in_data_i, input  in_ready_o);
    modport slave  (input  in_valid_i, input  in_data_i, output in_ready_o);

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. done_c marks the last cycle of the stop bit; a start_i in
// that cycle chains the next start bit with no idle gap.
module uart_tx_byte
    import softmax_uart_pkg::*;
#(
    parameter int unsigned BIT_CLKS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       done_c,
    output logic       tx_o
);

    localparam int unsigned CNT_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);

    byte_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        sh_q, sh_d;
    logic              tx_q, tx_d;
    logic              bit_end_c;

    assign bit_end_c = (cnt_q == CNT_LAST);
    assign tx_o      = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        done_c  = 1'b0;

        if (state_q != BS_IDLE) begin
            cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            BS_IDLE: begin
                if (start_i) begin
                    state_d = BS_START;
                    tx_d    = 1'b0;
                    sh_d    = data_i;
                    cnt_d   = '0;
                end
            end
            BS_START: begin
                if (bit_end_c) begin
                    state_d = BS_DATA;
                    tx_d    = sh_q[0];
                    idx_d   = 3'd0;
                end
            end
            BS_DATA: begin
                if (bit_end_c) begin
                    if (idx_q == 3'd7) begin
                        state_d = BS_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                    end
                end
            end
            BS_STOP: begin
                if (bit_end_c) begin
                    done_c = 1'b1;
                    if (start_i) begin
                        state_d = BS_START;
                        tx_d    = 1'b0;
                        sh_d    = data_i;
                    end else begin
                        state_d = BS_IDLE;
                    end
                end
            end
            default: state_d = BS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BS_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/uart_softmax_tx.sv
// Softmax result transmitter: word FSM splitting each Q6.10 word into LO/HI UART
// bytes, holding register and frame counter with a frame-complete pulse.
module uart_softmax_tx
    import softmax_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned BAUD    = 1_000_000,
    parameter int unsigned N_WORDS = FRAME_WORDS,
    parameter int unsigned W       = Q_W
) (
    input  logic               clk,
    input  logic               rst,
    uart_softmax_tx_if.slave   in_if,
    output logic               uart_tx_o,
    output logic               busy_o,
    output logic               frame_done_o
);

    localparam int unsigned BIT_CLKS = bit_clks(CLK_HZ, BAUD);
    localparam int unsigned WC_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(N_WORDS - 1);

    word_state_t      state_q, state_d;
    logic [W-1:0]     hold_q, hold_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             byte_start_c;
    logic [7:0]       byte_data_c;
    logic             byte_done_c;

    // LO byte is launched from the live input on acceptance, HI byte from the hold register.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        word_cnt_d   = word_cnt_q;
        frame_done_d = 1'b0;
        byte_start_c = 1'b0;
        byte_data_c  = hold_q[W-1:8];

        case (state_q)
            WS_IDLE: begin
                if (in_if.in_valid_i) begin
                    hold_d       = in_if.in_data_i;
                    byte_start_c = 1'b1;
                    byte_data_c  = in_if.in_data_i[7:0];
                    state_d      = WS_SEND_LO;
                end
            end
            WS_SEND_LO: begin
                if (byte_done_c) begin
                    byte_start_c = 1'b1;
                    state_d      = WS_SEND_HI;
                end
            end
            WS_SEND_HI: begin
                if (byte_done_c) begin
                    state_d = WS_IDLE;
                    if (word_cnt_q == WC_LAST) begin
                        word_cnt_d   = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                    end
                end
            end
            default: state_d = WS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WS_IDLE;
            hold_q       <= '0;
            word_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            word_cnt_q   <= word_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    uart_tx_byte #(
        .BIT_CLKS (BIT_CLKS)
    ) u_byte (
        .clk     (clk),
        .rst     (rst),
        .start_i (byte_start_c),
        .data_i  (byte_data_c),
        .done_c  (byte_done_c),
        .tx_o    (uart_tx_o)
    );

    assign in_if.in_ready_o = (state_q == WS_IDLE);
    assign busy_o           = (state_q != WS_IDLE);
    assign frame_done_o     = frame_done_q;

endmodule

// File: doc/uart_softmax_tx.md
# uart_softmax_tx

Transmit side of the softmax UART link. Accepts Q6.10 softmax result words from the compute core over a valid/ready handshake and serializes each word as two 8N1 UART bytes, low byte first, on `uart_tx_o`. Counts words into frames of `N_WORDS` (64 words = 128 bytes, mirroring the 128-byte request frame) and flags frame completion. Sits between the softmax core output and the board TX pin inside `uart_softmax_top`.

## Interface
- `CLK_HZ`, default 100000000: system clock frequency in Hz.
- `BAUD`, default 1000000: line rate in bit/s. `BIT_CLKS = CLK_HZ/BAUD`, integer division; must be >= 4.
- `N_WORDS`, default 64: words per frame.
- `W`, default 16: word width. Q6.10. Fixed at 16 (two bytes).

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid_i` in 1: the word on `in_data_i` is valid.
- `in_data_i` in 16: Q6.10 result word.
- `in_ready_o` out 1: the block accepts a word this cycle.
- `uart_tx_o` out 1: serial line, idle high.
- `busy_o` out 1: a word is in flight.
- `frame_done_o` out 1: one-cycle pulse when the last byte of a frame finishes.

## Operation
- Word FSM states: IDLE, SEND_LO, SEND_HI.
- IDLE:
  - `in_ready_o` = 1.
  - A word is accepted when `in_valid_i & in_ready_o`; the word is latched into a holding register and the FSM goes to SEND_LO.
- SEND_LO: the byte serializer sends `hold[7:0]`. When its stop bit completes, the FSM goes to SEND_HI.
- SEND_HI: the serializer sends `hold[15:8]`. When its stop bit completes, the FSM returns to IDLE and the word counter increments.
- Byte serializer states: IDLE, START, DATA, STOP.
  - START drives 0.
  - DATA drives 8 bits LSB-first.
  - STOP drives 1.
  - Each state lasts exactly `BIT_CLKS` cycles, timed by a bit-period counter (width `$clog2(BIT_CLKS)`) and a 3-bit bit index.
- Word counter:
  - `$clog2(N_WORDS)` bits.
  - When the HI byte of word `N_WORDS-1` completes, `frame_done_o` pulses and the counter wraps to 0.
  - No other wrap source exists.
- `busy_o` = (word FSM != IDLE).
- `in_ready_o` = (word FSM == IDLE). The holding register is never overwritten while busy.
- Words are sent verbatim; there is no arithmetic on the data.

## Timing
- Reset values (asserted asynchronously):
  - `uart_tx_o` = 1.
  - `busy_o` = 0.
  - `frame_done_o` = 0.
  - `in_ready_o` = 1.
  - Both FSMs in IDLE; all counters 0.
- Reset mid-byte:
  - The line returns high immediately.
  - The partial byte is abandoned and the word counter clears.
  - The next frame starts at word 0.
- Latency: a word is accepted on edge t; the start bit begins at t+1 (`uart_tx_o` falls one cycle after acceptance).
- Byte duration: 10·`BIT_CLKS` cycles, i.e. 1000 cycles at the default parameters.
- The HI start bit immediately follows the LO stop bit, with no idle gap.
- Between words there is exactly one IDLE cycle (line high) before the next word can be accepted. The minimum word period is therefore 20·`BIT_CLKS` + 1 cycles.
- `frame_done_o` is asserted in the same cycle the FSM re-enters IDLE after the final HI stop bit.
- `in_valid_i` held high while busy: the data is neither accepted nor lost. The source must hold it stable until `in_ready_o`.
- `in_valid_i` deasserting while `in_ready_o` = 1 is legal (no acceptance).

## Structure
- Shared package `softmax_uart_pkg`:
  - `BIT_CLKS` function of `CLK_HZ`/`BAUD`.
  - `Q_W` = 16 and `Q_FRAC` = 10.
  - Default frame length 64.
  - Word and byte FSM state typedefs.
- Sub-module `uart_tx_byte`:
  - 8N1 serializer with `start`, `data[7:0]`, `done` pulse and `tx`.
  - Parameterized by `BIT_CLKS`.
  - Reused by any other byte source in `uart_softmax_top`.
- The top level holds the word FSM, holding register and frame counter.

## Test plan
- Single word: accept `0x0400` -> line carries byte `0x00` then `0x04`. Start falls one cycle after acceptance. Each bit lasts exactly 100 clk. A monitor decodes the word as 1.0.
- Full frame: stream 64 words `0x0000`..`0x003F` with `in_valid_i` always high -> 128 bytes in LO/HI order. `frame_done_o` pulses exactly once, after byte 127. Each inter-word gap is exactly one idle cycle.
- Backpressure: assert `in_valid_i` with `0xFFE9` while busy -> `in_ready_o` = 0 with no acceptance. The word is sent as `0xE9`, `0xFF` after the current word finishes, and decodes to −0.0225 approximately.
- Reset mid-byte: assert `rst` during bit 3 of a LO byte -> `uart_tx_o` = 1 within the same cycle, `busy_o` = 0. The next word is counted as word 0; `frame_done_o` follows only after 64 more words.
- Frame wrap: send 130 words -> `frame_done_o` pulses after words 64 and 128 only. The counter reads 2 at the end.
- Timing sweep with `BAUD` = 115200 -> the bit period is 868 clk, measured over a full byte.
